// File: rtl/uart_tx_feeder.sv
// Byte FIFO ahead of the UART transmitter. Issue latency is 2 cycles from write into an empty FIFO.
// Writes while full are dropped and flagged on OVF. Issue waits for a full Busy high/low cycle before the next word.
module uart_tx_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   WR_DATA,
   input  logic                    WR_EN,
   output logic                    FULL,
   output logic                    EMPTY,
   output logic [$clog2(DEPTH):0]  COUNT,
   output logic                    OVF,
   input  logic                    Busy,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_DATA_VALID
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_HI = 2'd1;
   localparam logic [1:0] WAIT_LO = 2'd2;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_vld_q, tx_vld_d;
   logic                  ovf_q, ovf_d;

   logic full, empty, push, pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Full is judged on registered pointers, so a same-cycle pop cannot rescue a write.
   assign push = WR_EN && !full;
   assign pop  = (state_q == IDLE) && !empty && !Busy;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      state_d   = state_q;
      tx_data_d = tx_data_q;
      tx_vld_d  = 1'b0;
      ovf_d     = WR_EN && full;

      if (push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
               tx_vld_d  = 1'b1;
               rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
               state_d   = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (Busy) begin
               state_d = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!Busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         state_q   <= IDLE;
         tx_data_q <= '0;
         tx_vld_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         tx_vld_q  <= tx_vld_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= WR_DATA;
      end
   end

   assign FULL          = full;
   assign EMPTY         = empty;
   assign COUNT         = wr_ptr_q - rd_ptr_q;
   assign OVF           = ovf_q;
   assign TX_P_DATA     = tx_data_q;
   assign TX_DATA_VALID = tx_vld_q;

endmodule
